// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment display arbiter
package seg_pkg;
  typedef logic [6:0] seg_t;
  typedef seg_t [7:0] frame_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, BLANK} arb_state_t;
endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: scan prescaler producing a one-cycle tick and a 3-bit digit index
// Ports: CLK100MHZ clock, CPU_RESETN async active-low reset,
//        tick one-cycle pulse per SCAN_DIV cycles, idx digit index advancing after each tick
module seg_scan_timer #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  output logic       tick,
  output logic [2:0] idx
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] pre;
  logic          wrap;
  assign wrap = pre == PW'(SCAN_DIV - 1);
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      pre  <= '0;
      tick <= 1'b0;
      idx  <= 3'd0;
    end else begin
      pre  <= wrap ? '0 : pre + 1'b1;
      tick <= wrap;
      idx  <= idx + 3'(tick);
    end
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner arbitration of an 8-digit active-low 7-segment display
// Ports: CLK100MHZ clock, CPU_RESETN async active-low reset, req/upd per-producer request and
//        frame-update strobe, frame0/frame1 producer frames, gnt one-hot owner, AN/A2G display pins,
//        tick scan-tick pulse. Define SEG_ARB_PREEMPT_EN to force release after MAX_TICKS when contested.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 100_000,
  parameter int HOLD_TICKS  = 4_000,
  parameter int BLANK_TICKS = 800
`ifdef SEG_ARB_PREEMPT_EN
  , parameter int MAX_TICKS = 16_000
`endif
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [1:0] req,
  input  logic [1:0] upd,
  input  frame_t     frame0,
  input  frame_t     frame1,
  output logic [1:0] gnt,
  output logic [7:0] AN,
  output seg_t       A2G,
  output logic       tick
);
`ifdef SEG_ARB_PREEMPT_EN
  localparam int CAP = MAX_TICKS;
`else
  localparam int CAP = HOLD_TICKS;
`endif
  localparam int HW = $clog2(CAP + 2);
  localparam int BW = $clog2(BLANK_TICKS + 2);
  arb_state_t    state, nxt;
  frame_t        fbuf;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blank_cnt;
  logic          last_owner;
  logic [2:0]    idx;
  logic          own, owning, pick, rel, pre;
  seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .tick      (tick),
    .idx       (idx)
  );
  assign own    = state == OWN1;
  assign owning = state == OWN0 || state == OWN1;
  assign pick   = req == 2'b11 ? !last_owner : req[1];
`ifdef SEG_ARB_PREEMPT_EN
  assign pre = hold_cnt == HW'(MAX_TICKS) && req[!own];
`else
  assign pre = 1'b0;
`endif
  assign rel = owning && ((!req[own] && hold_cnt >= HW'(HOLD_TICKS)) || pre);
  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? (|req ? (pick ? OWN1 : OWN0) : IDLE) :
          state == BLANK ? ((tick && blank_cnt == BW'(BLANK_TICKS - 1)) ? IDLE : BLANK) :
          rel            ? (BLANK_TICKS == 0 ? IDLE : BLANK) : state;
  end
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      fbuf       <= {8{SEG_BLANK}};
      hold_cnt   <= '0;
      blank_cnt  <= '0;
      last_owner <= 1'b1;
    end else begin
      if (state == IDLE && |req) begin
        fbuf       <= pick ? frame1 : frame0;
        hold_cnt   <= '0;
        last_owner <= pick;
      end else if (owning) begin
        if (upd[own]) fbuf <= own ? frame1 : frame0;
        if (tick && hold_cnt != HW'(CAP)) hold_cnt <= hold_cnt + 1'b1;
      end
      blank_cnt <= state != BLANK ? '0 : blank_cnt + BW'(tick);
    end
  assign gnt = {state == OWN1, state == OWN0};
  assign AN  = owning ? ~(8'd1 << idx) : 8'hFF;
  assign A2G = owning ? fbuf[idx] : SEG_BLANK;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: randomized self-checking bench against a behavioural arbitration model
module tb_seg_display_arbiter;
  import seg_pkg::*;
  localparam int SD = 4;
  localparam int HT = 2;
  localparam int BT = 1;
`ifdef SEG_ARB_PREEMPT_EN
  localparam int MT = 3;
  localparam int CAPM = MT;
`else
  localparam int CAPM = HT;
`endif
  logic       CLK100MHZ = 1'b0;
  logic       CPU_RESETN = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] upd = 2'b00;
  frame_t     frame0 = '0;
  frame_t     frame1 = '0;
  logic [1:0] gnt;
  logic [7:0] AN;
  seg_t       A2G;
  logic       tick;
  int vectors = 0;
  int miscompares = 0;
  int e, mode, who, held, blanked, last;
  frame_t shown;
  seg_display_arbiter #(
    .SCAN_DIV(SD), .HOLD_TICKS(HT), .BLANK_TICKS(BT)
`ifdef SEG_ARB_PREEMPT_EN
    , .MAX_TICKS(MT)
`endif
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .req       (req),
    .upd       (upd),
    .frame0    (frame0),
    .frame1    (frame1),
    .gnt       (gnt),
    .AN        (AN),
    .A2G       (A2G),
    .tick      (tick)
  );
  always #5 CLK100MHZ = ~CLK100MHZ;
  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, got, exp, e);
    end
  endtask
  task automatic model_reset();
    e = 0; mode = 0; who = 0; held = 0; blanked = 0; last = 1;
    shown = {8{SEG_BLANK}};
  endtask
  task automatic model_edge();
    bit tick_before;
    bit release_now;
    tick_before = e > 0 && e % SD == 0;
    e++;
    if (mode == 0) begin
      if (req != 2'b00) begin
        who = req == 2'b11 ? 1 - last : (req == 2'b10 ? 1 : 0);
        last = who; held = 0; mode = 1;
        shown = who == 1 ? frame1 : frame0;
      end
    end else if (mode == 1) begin
      release_now = !req[who] && held >= HT;
`ifdef SEG_ARB_PREEMPT_EN
      release_now = release_now || (held == MT && req[1-who]);
`endif
      if (release_now) begin
        mode = BT > 0 ? 2 : 0;
        blanked = 0;
      end else begin
        if (upd[who]) shown = who == 1 ? frame1 : frame0;
        if (tick_before && held < CAPM) held++;
      end
    end else if (tick_before) begin
      if (blanked == BT - 1) mode = 0;
      else blanked++;
    end
  endtask
  task automatic check_all();
    int d;
    d = e == 0 ? 0 : ((e - 1) / SD) % 8;
    cmp("tick", 32'(tick), 32'(e > 0 && e % SD == 0));
    cmp("gnt", 32'(gnt), mode == 1 ? 32'(1 << who) : 32'd0);
    cmp("AN", 32'(AN), mode == 1 ? 32'(8'hFF ^ (8'd1 << d)) : 32'hFF);
    cmp("A2G", 32'(A2G), mode == 1 ? 32'(shown[d]) : 32'h7F);
  endtask
  task automatic cyc();
    @(posedge CLK100MHZ);
    if (CPU_RESETN) model_edge();
    @(negedge CLK100MHZ);
    check_all();
  endtask
  initial begin
    model_reset();
    cyc();
    cyc();
    cmp("rst_AN", 32'(AN), 32'hFF);
    cmp("rst_A2G", 32'(A2G), 32'h7F);
    cmp("rst_gnt", 32'(gnt), 32'h0);
    CPU_RESETN = 1'b1;
    frame0 = frame_t'({$urandom, $urandom});
    frame1 = frame_t'({$urandom, $urandom});
    frame0[0] = 7'h40;
    req = 2'b01;
    cyc();
    cmp("first_gnt", 32'(gnt), 32'h1);
    cmp("first_AN", 32'(AN), 32'hFE);
    cmp("first_A2G", 32'(A2G), 32'h40);
    for (int i = 0; i < 40; i++) cyc();
    req = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) req[$urandom_range(0, 1)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0) req = 2'b11;
      upd = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 5) == 0) frame0 = frame_t'({$urandom, $urandom});
      if ($urandom_range(0, 5) == 0) frame1 = frame_t'({$urandom, $urandom});
      cyc();
    end
    req = 2'b10;
    upd = 2'b00;
    for (int i = 0; i < 200 && !(mode == 1 && who == 1); i++) cyc();
    cmp("reach_own1", 32'(mode == 1 && who == 1), 32'd1);
    @(posedge CLK100MHZ);
    #2 CPU_RESETN = 1'b0;
    #1;
    cmp("async_AN", 32'(AN), 32'hFF);
    cmp("async_gnt", 32'(gnt), 32'h0);
    cmp("async_A2G", 32'(A2G), 32'h7F);
    model_reset();
    cyc();
    CPU_RESETN = 1'b1;
    req = 2'b11;
    cyc();
    cmp("post_rst_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) req[$urandom_range(0, 1)] ^= 1'b1;
      upd = 2'($urandom);
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
